// File: rtl/pc_sequencer_if.sv
// Fetch-redirect bundle between the hazard/ID/EX control logic and the next-PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned NUM_IRQ = 3
);
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_4;
  logic               stall;
  logic               halt;
  logic               jump;
  logic [ADDR_W-1:0]  jump_target;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               eret;
  logic               irq_enable;
  logic [NUM_IRQ-1:0] irq_req;
  logic               pc_en;
  logic               load_pc;
  logic [ADDR_W-1:0]  pc_new;
  logic               flush_if;
  logic               flush_id;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [ADDR_W-1:0]  epc;
  logic               in_isr;
  logic               halted;

  modport master (
    output pc, pc_4, stall, halt, jump, jump_target, branch_taken, branch_target,
           eret, irq_enable, irq_req,
    input  pc_en, load_pc, pc_new, flush_if, flush_id, irq_ack, epc, in_isr, halted
  );

  modport slave (
    input  pc, pc_4, stall, halt, jump, jump_target, branch_taken, branch_target,
           eret, irq_enable, irq_req,
    output pc_en, load_pc, pc_new, flush_if, flush_id, irq_ack, epc, in_isr, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates sequential fetch, jump, branch, interrupt entry, ERET and halt,
// and owns interrupt pending/acknowledge, EPC and the handler/halt state.
module pc_sequencer #(
  parameter int unsigned     ADDR_W   = 10,
  parameter int unsigned     NUM_IRQ  = 3,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(10'h3F0)
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_ISR  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [NUM_IRQ-1:0] pending, irq_req_d;
  logic [ADDR_W-1:0]  epc, epc_nxt;

  logic               irq_any;
  logic [NUM_IRQ-1:0] irq_sel;
  logic [ADDR_W-1:0]  irq_vec;

  logic               pc_en, load_pc, flush_if, flush_id;
  logic [ADDR_W-1:0]  pc_new;
  logic [NUM_IRQ-1:0] irq_ack;

  // Lowest pending index wins; its vector is VEC_BASE + 4*i modulo 2^ADDR_W.
  always_comb begin
    irq_any = |pending;
    irq_sel = '0;
    irq_vec = VEC_BASE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        irq_sel = NUM_IRQ'(1) << i;
        irq_vec = VEC_BASE + ADDR_W'(4 * i);
      end
    end
  end

  // Next-state and redirect decode, first matching condition wins.
  always_comb begin
    state_nxt = state;
    epc_nxt   = epc;
    pc_en     = 1'b0;
    load_pc   = 1'b0;
    pc_new    = '0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    irq_ack   = '0;
    if (!rst && state != ST_HALT) begin
      if (bus.halt) begin
        flush_if  = 1'b1;
        state_nxt = ST_HALT;
      end else if (state == ST_RUN && bus.irq_enable && irq_any && !bus.stall) begin
        pc_en     = 1'b1;
        load_pc   = 1'b1;
        pc_new    = irq_vec;
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        irq_ack   = irq_sel;
        state_nxt = ST_ISR;
        // Return to the redirect the interrupt pre-empted, otherwise the next sequential PC.
        if (bus.branch_taken)  epc_nxt = bus.branch_target;
        else if (bus.jump)     epc_nxt = bus.jump_target;
        else                   epc_nxt = bus.pc_4;
      end else if (bus.branch_taken) begin
        pc_en    = 1'b1;
        load_pc  = 1'b1;
        pc_new   = bus.branch_target;
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (bus.eret && !bus.stall && state == ST_ISR) begin
        pc_en     = 1'b1;
        load_pc   = 1'b1;
        pc_new    = epc;
        flush_if  = 1'b1;
        state_nxt = ST_RUN;
      end else if (bus.jump && !bus.stall) begin
        pc_en    = 1'b1;
        load_pc  = 1'b1;
        pc_new   = bus.jump_target;
        flush_if = 1'b1;
      end else if (!bus.stall) begin
        pc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // New rising edges set pending even on the cycle that acknowledges the same line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      irq_req_d <= '0;
      epc       <= '0;
    end else begin
      pending   <= (pending & ~irq_ack) | (bus.irq_req & ~irq_req_d);
      irq_req_d <= bus.irq_req;
      epc       <= epc_nxt;
    end
  end

  assign bus.pc_en    = pc_en;
  assign bus.load_pc  = load_pc;
  assign bus.pc_new   = pc_new;
  assign bus.flush_if = flush_if;
  assign bus.flush_id = flush_id;
  assign bus.irq_ack  = irq_ack;
  assign bus.epc      = epc;
  assign bus.in_isr   = (state == ST_ISR);
  assign bus.halted   = (state == ST_HALT);

  a_redirect_known: assert property (@(posedge clk) disable iff (rst)
    load_pc |-> !$isunknown(pc_new) && !$isunknown(bus.pc));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, interrupt entry/return, branch/jump/stall priority, halt.
module tb_pc_sequencer;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned NUM_IRQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .VEC_BASE(10'h3F0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.pc = '0;            bus.pc_4 = 10'h001;
    bus.stall = 1'b0;       bus.halt = 1'b0;
    bus.jump = 1'b0;        bus.jump_target = '0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.eret = 1'b0;        bus.irq_enable = 1'b0;
    bus.irq_req = '0;

    // Reset state and outputs forced low while rst is high
    tick(); tick();
    chk("rst_pc_en",  32'(bus.pc_en), 32'h0);
    chk("rst_epc",    32'(bus.epc), 32'h0);
    chk("rst_in_isr", 32'(bus.in_isr), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    rst = 1'b0;
    #1;
    chk("seq_pc_en",   32'(bus.pc_en), 32'h1);
    chk("seq_load_pc", 32'(bus.load_pc), 32'h0);

    // T2: lines 1 and 2 rise; line 1 taken first
    bus.irq_enable = 1'b1; bus.pc_4 = 10'h021; bus.irq_req = 3'b110;
    #1;
    chk("t2_no_take_yet", 32'(bus.irq_ack), 32'h0);
    tick();
    chk("t2_ack",      32'(bus.irq_ack), 32'b010);
    chk("t2_pc_new",   32'(bus.pc_new), 32'h3F4);
    chk("t2_load_pc",  32'(bus.load_pc), 32'h1);
    chk("t2_flush_if", 32'(bus.flush_if), 32'h1);
    chk("t2_flush_id", 32'(bus.flush_id), 32'h1);
    tick();
    chk("t2_in_isr",   32'(bus.in_isr), 32'h1);
    chk("t2_epc",      32'(bus.epc), 32'h021);
    chk("t2_pending",  32'(dut.pending), 32'b100);
    chk("t2_no_nest",  32'(bus.irq_ack), 32'h0);
    chk("t2_isr_seq",  32'(bus.load_pc), 32'h0);

    // T5: ERET returns, pending line 2 taken the next cycle
    bus.eret = 1'b1;
    #1;
    chk("t5_pc_new",   32'(bus.pc_new), 32'h021);
    chk("t5_load_pc",  32'(bus.load_pc), 32'h1);
    chk("t5_flush_id", 32'(bus.flush_id), 32'h0);
    tick();
    bus.eret = 1'b0; bus.pc_4 = 10'h022;
    #1;
    chk("t5_in_isr",   32'(bus.in_isr), 32'h0);
    chk("t5_ack",      32'(bus.irq_ack), 32'b100);
    chk("t5_pc_new2",  32'(bus.pc_new), 32'h3F8);
    tick();
    chk("t5_epc",      32'(bus.epc), 32'h022);
    bus.eret = 1'b1;
    #1;
    chk("t5_ret2",     32'(bus.pc_new), 32'h022);
    tick();
    bus.eret = 1'b0;

    // T3: interrupt pre-empts a taken branch; EPC gets the branch target
    bus.irq_req = 3'b111;
    #1;
    chk("t3_idle", 32'(bus.load_pc), 32'h0);
    tick();
    bus.branch_taken = 1'b1; bus.branch_target = 10'h080;
    #1;
    chk("t3_pc_new", 32'(bus.pc_new), 32'h3F0);
    chk("t3_ack",    32'(bus.irq_ack), 32'b001);
    tick();
    chk("t3_epc",    32'(bus.epc), 32'h080);
    bus.branch_taken = 1'b0; bus.eret = 1'b1;
    #1;
    chk("t3_ret", 32'(bus.pc_new), 32'h080);
    tick();
    bus.eret = 1'b0;

    // T4: stall blocks jump and interrupt; released stall lets interrupt win over jump
    bus.irq_req = 3'b000;
    tick();
    bus.irq_req = 3'b001; bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 10'h100;
    #1;
    chk("t4_stall_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    chk("t4_stall_noack", 32'(bus.irq_ack), 32'h0);
    chk("t4_stall_hold",  32'(bus.pc_en), 32'h0);
    bus.stall = 1'b0;
    #1;
    chk("t4_ack",    32'(bus.irq_ack), 32'b001);
    chk("t4_pc_new", 32'(bus.pc_new), 32'h3F0);
    tick();
    chk("t4_epc", 32'(bus.epc), 32'h100);
    bus.jump = 1'b0; bus.eret = 1'b1; bus.stall = 1'b1;
    #1;
    chk("t4_eret_stall_en",   32'(bus.pc_en), 32'h0);
    chk("t4_eret_stall_load", 32'(bus.load_pc), 32'h0);
    bus.branch_taken = 1'b1; bus.branch_target = 10'h2AA;
    #1;
    chk("t4_br_stall_en",  32'(bus.pc_en), 32'h1);
    chk("t4_br_stall_pc",  32'(bus.pc_new), 32'h2AA);
    chk("t4_br_flush_id",  32'(bus.flush_id), 32'h1);
    tick();
    bus.branch_taken = 1'b0; bus.stall = 1'b0;
    #1;
    chk("t4_ret", 32'(bus.pc_new), 32'h100);
    tick();
    bus.eret = 1'b0;
    chk("t4_run", 32'(bus.in_isr), 32'h0);

    // Interrupt disabled: pending line is not taken
    bus.irq_req = 3'b000; bus.irq_enable = 1'b0;
    tick();
    bus.irq_req = 3'b010;
    tick();
    chk("dis_noack", 32'(bus.irq_ack), 32'h0);
    chk("dis_seq",   32'(bus.pc_en), 32'h1);

    // T6: halt beats branch, then sticks until reset
    bus.halt = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 10'h055;
    #1;
    chk("t6_pc_en",    32'(bus.pc_en), 32'h0);
    chk("t6_load_pc",  32'(bus.load_pc), 32'h0);
    chk("t6_flush_if", 32'(bus.flush_if), 32'h1);
    tick();
    chk("t6_halted", 32'(bus.halted), 32'h1);
    bus.halt = 1'b0; bus.branch_taken = 1'b0; bus.irq_enable = 1'b1; bus.eret = 1'b1;
    #1;
    chk("t6_hold_en",  32'(bus.pc_en), 32'h0);
    chk("t6_hold_ack", 32'(bus.irq_ack), 32'h0);
    chk("t6_hold_fl",  32'(bus.flush_if), 32'h0);
    tick();
    chk("t6_still_halted", 32'(bus.halted), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_halted", 32'(bus.halted), 32'h0);
    tick();
    rst = 1'b0; bus.eret = 1'b0; bus.jump = 1'b1; bus.jump_target = 10'h012;
    #1;
    chk("jmp_pc_new",  32'(bus.pc_new), 32'h012);
    chk("jmp_flushid", 32'(bus.flush_id), 32'h0);
    tick();
    chk("t1_ack",    32'(bus.irq_ack), 32'b010);
    chk("t1_vec",    32'(bus.pc_new), 32'h3F4);
    tick();
    chk("t1_in_isr", 32'(bus.in_isr), 32'h1);
    chk("t1_epc",    32'(bus.epc), 32'h012);

    // T1: reset mid-handler abandons it
    rst = 1'b1;
    #1;
    chk("t1_rst_epc",     32'(bus.epc), 32'h0);
    chk("t1_rst_in_isr",  32'(bus.in_isr), 32'h0);
    chk("t1_rst_pending", 32'(dut.pending), 32'h0);
    chk("t1_rst_pc_en",   32'(bus.pc_en), 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
